// File: rtl/gpu_regfile_ctx.sv
// Per-warp GPR + predicate file: 1-cycle registered reads, IDLE-only writes, and a beat-wise context save/restore engine.
// Save beats hold until ctx_out_ready; restore beats are taken whenever ctx_in_valid is high. REGFILE_BYPASS_EN enables write-to-read forwarding.
module gpu_regfile_ctx #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 16,
    parameter  int NRD    = 4,
    parameter  int NWR    = 2,
    parameter  int NPRED  = 8,
    parameter  int CHUNK  = 4,
    localparam int AW     = $clog2(NREGS),
    localparam int PW     = $clog2(NPRED),
    localparam int BEATS  = NREGS / CHUNK,
    localparam int BW     = $clog2(BEATS) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*AW-1:0]       rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*AW-1:0]       wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic [PW-1:0]           prd_addr,
    output logic                    prd_out,
    input  logic                    pwr_en,
    input  logic [PW-1:0]           pwr_addr,
    input  logic                    pwr_val,
    input  logic                    save_req,
    input  logic                    restore_req,
    output logic                    busy,
    output logic                    ctx_done,
    output logic                    ctx_out_valid,
    input  logic                    ctx_out_ready,
    output logic [CHUNK*DATA_W-1:0] ctx_out_data,
    output logic [NPRED-1:0]        ctx_out_pred,
    input  logic                    ctx_in_valid,
    output logic                    ctx_in_ready,
    input  logic [CHUNK*DATA_W-1:0] ctx_in_data,
    input  logic [NPRED-1:0]        ctx_in_pred,
    output logic [BW-1:0]           ctx_beat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    done_q, done_d;

    logic [DATA_W-1:0]       gpr_q [NREGS];
    logic [DATA_W-1:0]       gpr_d [NREGS];
    // Predicate 0 is constant true, so only indices 1.. are stored.
    logic [NPRED-1:1]        pred_q, pred_d;

    logic [NRD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                    prd_q, prd_d;

    logic                    last_beat;
    logic                    in_fire;
    logic [NPRED-1:0]        pred_now;
    logic [NPRED-1:0]        pred_next;
    logic                    unused_in_pred0;

    assign last_beat       = (beat_q == BW'(BEATS - 1));
    assign in_fire         = (state_q == ST_RESTORE) && ctx_in_valid;
    assign pred_now        = {pred_q, 1'b1};
    assign pred_next       = {pred_d, 1'b1};
    assign unused_in_pred0 = ctx_in_pred[0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (save_req) begin
                    state_d = ST_SAVE;
                end else if (restore_req) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_SAVE: begin
                if (ctx_out_ready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ST_RESTORE: begin
                if (ctx_in_valid) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    // Port writes only land in IDLE; later ports overwrite earlier ones on collision.
    always_comb begin
        gpr_d  = gpr_q;
        pred_d = pred_q;
        if (state_q == ST_IDLE) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p]) begin
                    gpr_d[wr_addr[p*AW +: AW]] = wr_data[p*DATA_W +: DATA_W];
                end
            end
            if (pwr_en && (pwr_addr != '0)) begin
                pred_d[pwr_addr] = pwr_val;
            end
        end else if (in_fire) begin
            for (int j = 0; j < CHUNK; j++) begin
                gpr_d[AW'(int'(beat_q) * CHUNK + j)] = ctx_in_data[j*DATA_W +: DATA_W];
            end
            if (last_beat) begin
                pred_d = ctx_in_pred[NPRED-1:1];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_d[k*DATA_W +: DATA_W] = gpr_d[rd_addr[k*AW +: AW]];
`else
            rd_data_d[k*DATA_W +: DATA_W] = gpr_q[rd_addr[k*AW +: AW]];
`endif
        end
`ifdef REGFILE_BYPASS_EN
        prd_d = pred_next[prd_addr];
`else
        prd_d = pred_now[prd_addr];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
            pred_q    <= '0;
            rd_data_q <= '0;
            prd_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            pred_q    <= pred_d;
            rd_data_q <= rd_data_d;
            prd_q     <= prd_d;
        end
    end

    // Save data comes straight from the array; it is stable because writes are blocked while busy.
    always_comb begin
        ctx_out_data = '0;
        for (int j = 0; j < CHUNK; j++) begin
            ctx_out_data[j*DATA_W +: DATA_W] = gpr_q[AW'(int'(beat_q) * CHUNK + j)];
        end
    end

    assign ctx_out_pred  = pred_now;
    assign ctx_out_valid = (state_q == ST_SAVE);
    assign ctx_in_ready  = (state_q == ST_RESTORE);
    assign busy          = (state_q != ST_IDLE);
    assign ctx_done      = done_q;
    assign ctx_beat      = beat_q;
    assign rd_data       = rd_data_q;
    assign prd_out       = prd_q;

endmodule

// File: tb/tb_gpu_regfile_ctx.sv
// Directed bench for gpu_regfile_ctx: reset, write collisions, predicates, save, restore and write blocking.
module tb_gpu_regfile_ctx;

    logic        clk;
    logic        rst_n;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  prd_addr;
    logic        prd_out;
    logic        pwr_en;
    logic [2:0]  pwr_addr;
    logic        pwr_val;
    logic        save_req;
    logic        restore_req;
    logic        busy;
    logic        ctx_done;
    logic        ctx_out_valid;
    logic        ctx_out_ready;
    logic [63:0] ctx_out_data;
    logic [7:0]  ctx_out_pred;
    logic        ctx_in_valid;
    logic        ctx_in_ready;
    logic [63:0] ctx_in_data;
    logic [7:0]  ctx_in_pred;
    logic [2:0]  ctx_beat;

    int n_chk;
    int n_err;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] EXP_RDW_R5  = 16'h2222;
    localparam logic [15:0] EXP_RST_R12 = 16'h500C;
`else
    localparam logic [15:0] EXP_RDW_R5  = 16'h0000;
    localparam logic [15:0] EXP_RST_R12 = 16'h0000;
`endif

    gpu_regfile_ctx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .prd_addr      (prd_addr),
        .prd_out       (prd_out),
        .pwr_en        (pwr_en),
        .pwr_addr      (pwr_addr),
        .pwr_val       (pwr_val),
        .save_req      (save_req),
        .restore_req   (restore_req),
        .busy          (busy),
        .ctx_done      (ctx_done),
        .ctx_out_valid (ctx_out_valid),
        .ctx_out_ready (ctx_out_ready),
        .ctx_out_data  (ctx_out_data),
        .ctx_out_pred  (ctx_out_pred),
        .ctx_in_valid  (ctx_in_valid),
        .ctx_in_ready  (ctx_in_ready),
        .ctx_in_data   (ctx_in_data),
        .ctx_in_pred   (ctx_in_pred),
        .ctx_beat      (ctx_beat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] seq4(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        prd_addr = '0; pwr_en = 1'b0; pwr_addr = '0; pwr_val = 1'b0;
        save_req = 1'b0; restore_req = 1'b0; ctx_out_ready = 1'b0;
        ctx_in_valid = 1'b0; ctx_in_data = '0; ctx_in_pred = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(ctx_done), 64'd0);
        chk("rst_out_valid", 64'(ctx_out_valid), 64'd0);
        chk("rst_in_ready", 64'(ctx_in_ready), 64'd0);
        chk("rst_beat", 64'(ctx_beat), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_prd_out", 64'(prd_out), 64'd0);
        rst_n = 1'b1;

        // Both ports hit r5 in one cycle while r5 is also read.
        wr_en = 2'b11; wr_addr = {4'd5, 4'd5}; wr_data = {16'h2222, 16'h1111};
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
        step();
        chk("rdw_same_cycle_r5", 64'(rd_data[15:0]), 64'(EXP_RDW_R5));
        wr_en = 2'b00;
        step();
        chk("collision_r5", 64'(rd_data[15:0]), 64'h2222);

        wr_en = 2'b11; wr_addr = {4'd7, 4'd6}; wr_data = {16'h7777, 16'h6666};
        step();
        wr_en = 2'b00;
        rd_addr = {4'd5, 4'd7, 4'd6, 4'd0};
        step();
        chk("multi_port_rd", rd_data, 64'h2222_7777_6666_0000);

        for (int i = 0; i < 16; i += 2) begin
            wr_en   = 2'b11;
            wr_addr = {4'(i + 1), 4'(i)};
            wr_data = {16'hA000 + 16'(i + 1), 16'hA000 + 16'(i)};
            step();
        end
        wr_en = 2'b00;
        pwr_en = 1'b1; pwr_val = 1'b1;
        pwr_addr = 3'd2; step();
        pwr_addr = 3'd5; step();
        pwr_addr = 3'd7; step();
        pwr_addr = 3'd0; pwr_val = 1'b0; step();
        pwr_en = 1'b0;
        rd_addr = {4'd15, 4'd14, 4'd13, 4'd12};
        prd_addr = 3'd0;
        step();
        chk("load_r12_r15", rd_data, 64'hA00F_A00E_A00D_A00C);
        chk("pred0_write_ignored", 64'(prd_out), 64'd1);
        prd_addr = 3'd2; step();
        chk("pred2_set", 64'(prd_out), 64'd1);
        prd_addr = 3'd1; step();
        chk("pred1_clear", 64'(prd_out), 64'd0);

        // Save with ready 0,1,0,1... and blocked writes mid-save.
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
        prd_addr = 3'd3;
        save_req = 1'b1; ctx_out_ready = 1'b0;
        step();
        chk("save_busy", 64'(busy), 64'd1);
        chk("save_valid", 64'(ctx_out_valid), 64'd1);
        chk("save_beat0_idx", 64'(ctx_beat), 64'd0);
        chk("save_beat0_data", ctx_out_data, 64'hA003_A002_A001_A000);
        chk("save_pred", 64'(ctx_out_pred), 64'hA5);
        save_req = 1'b0; ctx_out_ready = 1'b1;
        wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {16'h0000, 16'hBEEF};
        pwr_en = 1'b1; pwr_addr = 3'd3; pwr_val = 1'b1;
        step();
        chk("save_beat1_idx", 64'(ctx_beat), 64'd1);
        chk("save_beat1_data", ctx_out_data, 64'hA007_A006_A005_A004);
        ctx_out_ready = 1'b0; restore_req = 1'b1;
        step();
        chk("save_stall_idx", 64'(ctx_beat), 64'd1);
        chk("save_stall_data", ctx_out_data, 64'hA007_A006_A005_A004);
        chk("save_stall_valid", 64'(ctx_out_valid), 64'd1);
        ctx_out_ready = 1'b1; restore_req = 1'b0;
        step();
        chk("save_beat2_data", ctx_out_data, 64'hA00B_A00A_A009_A008);
        step();
        chk("save_beat3_idx", 64'(ctx_beat), 64'd3);
        chk("save_beat3_data", ctx_out_data, 64'hA00F_A00E_A00D_A00C);
        wr_en = 2'b00; pwr_en = 1'b0;
        step();
        chk("save_done_pulse", 64'(ctx_done), 64'd1);
        chk("save_done_busy", 64'(busy), 64'd0);
        chk("save_done_valid", 64'(ctx_out_valid), 64'd0);
        ctx_out_ready = 1'b0;
        step();
        chk("save_done_once", 64'(ctx_done), 64'd0);
        chk("busy_req_ignored", 64'(ctx_in_ready), 64'd0);
        chk("blocked_wr_r3", 64'(rd_data[15:0]), 64'hA003);
        chk("blocked_pwr_p3", 64'(prd_out), 64'd0);

        // Simultaneous requests pick SAVE; then reset lands at beat 2.
        save_req = 1'b1; restore_req = 1'b1;
        step();
        chk("both_req_save", 64'(ctx_out_valid), 64'd1);
        chk("both_req_not_restore", 64'(ctx_in_ready), 64'd0);
        save_req = 1'b0; restore_req = 1'b0; ctx_out_ready = 1'b1;
        step();
        step();
        chk("abort_at_beat2", 64'(ctx_beat), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(ctx_out_valid), 64'd0);
        chk("abort_beat", 64'(ctx_beat), 64'd0);
        chk("abort_rd_data", rd_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ctx_out_ready = 1'b0;
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd9};
        prd_addr = 3'd0;
        step();
        chk("abort_r9_cleared", 64'(rd_data[15:0]), 64'd0);
        chk("abort_pred0", 64'(prd_out), 64'd1);

        // Restore with gaps in ctx_in_valid.
        restore_req = 1'b1;
        step();
        chk("rest_busy", 64'(busy), 64'd1);
        chk("rest_in_ready", 64'(ctx_in_ready), 64'd1);
        chk("rest_no_out_valid", 64'(ctx_out_valid), 64'd0);
        restore_req = 1'b0;
        ctx_in_valid = 1'b1; ctx_in_data = seq4(16'h5000);
        step();
        chk("rest_beat1_idx", 64'(ctx_beat), 64'd1);
        ctx_in_valid = 1'b0;
        step();
        chk("rest_gap_idx", 64'(ctx_beat), 64'd1);
        ctx_in_valid = 1'b1; ctx_in_data = seq4(16'h5004);
        step();
        chk("rest_beat2_idx", 64'(ctx_beat), 64'd2);
        ctx_in_data = seq4(16'h5008);
        step();
        chk("rest_beat3_idx", 64'(ctx_beat), 64'd3);
        ctx_in_valid = 1'b0;
        step();
        chk("rest_gap_busy", 64'(busy), 64'd1);
        ctx_in_valid = 1'b1; ctx_in_data = seq4(16'h500C); ctx_in_pred = 8'h3C;
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd12};
        step();
        chk("rest_done_pulse", 64'(ctx_done), 64'd1);
        chk("rest_done_busy", 64'(busy), 64'd0);
        chk("rest_rdw_r12", 64'(rd_data[15:0]), 64'(EXP_RST_R12));
        ctx_in_valid = 1'b0;
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd9};
        prd_addr = 3'd0;
        step();
        chk("rest_r9", 64'(rd_data[15:0]), 64'h5009);
        chk("rest_pred0", 64'(prd_out), 64'd1);
        chk("rest_done_once", 64'(ctx_done), 64'd0);
        prd_addr = 3'd2; step();
        chk("rest_pred2", 64'(prd_out), 64'd1);
        prd_addr = 3'd1; step();
        chk("rest_pred1", 64'(prd_out), 64'd0);
        prd_addr = 3'd5; step();
        chk("rest_pred5", 64'(prd_out), 64'd1);
        rd_addr = {4'd15, 4'd14, 4'd13, 4'd12};
        step();
        chk("rest_r12_r15", rd_data, 64'h500F_500E_500D_500C);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
